// File: rtl/i2c_slave_mem.sv
`timescale 1ns/1ps
// i2c_slave_mem: I2C target with on-chip byte memory and EEPROM-style word addressing.
// SCL/SDA are oversampled on sys_clk; SDA is open-drain (driven 0 or released to z).
module i2c_slave_mem #(
    parameter logic [6:0]  DEVICE_ADDR = 7'b1010_011,
    parameter bit          ADDR_NUM    = 1'b1,
    parameter int unsigned MEM_AW      = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              i2c_scl,
    inout  wire               i2c_sda,
    output logic              busy,
    output logic              wr_valid,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int unsigned DEPTH = 1 << MEM_AW;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_ADDR_H, S_ADDR_H_ACK, S_ADDR_L, S_ADDR_L_ACK,
        S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic [1:0]        r_scl_sync, r_sda_sync;
    logic              r_scl_d, r_sda_d;
    state_t            r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift, r_addr_h, r_mem_q;
    logic [MEM_AW-1:0] r_ptr;
    logic              r_sda_oe, r_ack_hold, r_tx_first, r_rw, r_busy, r_wr_valid;
    logic [MEM_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_mem [DEPTH];

    logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop, w_last_bit;
    logic [7:0] w_rx_byte;
    logic [15:0] w_word;

    // Sync stages reset to the idle-bus level so release of reset never fakes an edge on a quiet bus
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda};
            r_scl_d    <= r_scl_sync[1];
            r_sda_d    <= r_sda_sync[1];
        end
    end

    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_sda_rise = w_sda & ~r_sda_d;
    assign w_sda_fall = ~w_sda & r_sda_d;
    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_rx_byte  = {r_shift[6:0], w_sda};
    assign w_word     = ADDR_NUM ? {r_addr_h, w_rx_byte} : {8'h00, w_rx_byte};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_addr_h   <= '0;
            r_ptr      <= '0;
            r_sda_oe   <= 1'b0;
            r_ack_hold <= 1'b0;
            r_tx_first <= 1'b0;
            r_rw       <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_start) begin
                r_state    <= S_DEV_ADDR;
                r_bit_cnt  <= '0;
                r_sda_oe   <= 1'b0;
                r_ack_hold <= 1'b0;
                r_tx_first <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV_ADDR, S_ADDR_H, S_ADDR_L, S_WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                case (r_state)
                                    S_DEV_ADDR: begin
                                        if (w_rx_byte[7:1] == DEVICE_ADDR) begin
                                            r_busy  <= 1'b1;
                                            r_rw    <= w_rx_byte[0];
                                            r_state <= S_DEV_ACK;
                                        end else begin
                                            r_busy  <= 1'b0;
                                            r_state <= S_WAIT_STOP;
                                        end
                                    end
                                    S_ADDR_H: begin
                                        r_addr_h <= w_rx_byte;
                                        r_state  <= S_ADDR_H_ACK;
                                    end
                                    S_ADDR_L: begin
                                        r_ptr   <= w_word[MEM_AW-1:0];
                                        r_state <= S_ADDR_L_ACK;
                                    end
                                    default: begin
                                        r_wr_valid <= 1'b1;
                                        r_wr_addr  <= r_ptr;
                                        r_wr_data  <= w_rx_byte;
                                        r_ptr      <= r_ptr + MEM_AW'(1);
                                        r_state    <= S_WR_ACK;
                                    end
                                endcase
                            end
                        end
                    end
                    // First fall after the 8th rise pulls SDA low, the next one ends the ACK slot
                    S_DEV_ACK, S_ADDR_H_ACK, S_ADDR_L_ACK, S_WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_hold) begin
                                r_sda_oe   <= 1'b1;
                                r_ack_hold <= 1'b1;
                            end else begin
                                r_ack_hold <= 1'b0;
                                r_sda_oe   <= 1'b0;
                                r_bit_cnt  <= '0;
                                case (r_state)
                                    S_DEV_ACK: begin
                                        if (r_rw) begin
                                            r_state  <= S_RD_BYTE;
                                            r_shift  <= {r_mem_q[6:0], 1'b1};
                                            r_sda_oe <= ~r_mem_q[7];
                                        end else begin
                                            r_state <= ADDR_NUM ? S_ADDR_H : S_ADDR_L;
                                        end
                                    end
                                    S_ADDR_H_ACK: r_state <= S_ADDR_L;
                                    default:      r_state <= S_WR_BYTE;
                                endcase
                            end
                        end
                    end
                    S_RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_tx_first) begin
                                r_tx_first <= 1'b0;
                                r_bit_cnt  <= '0;
                                r_shift    <= {r_mem_q[6:0], 1'b1};
                                r_sda_oe   <= ~r_mem_q[7];
                            end else if (w_last_bit) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= '0;
                                r_ptr     <= r_ptr + MEM_AW'(1);
                                r_state   <= S_RD_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_sda_oe  <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b1};
                            end
                        end
                    end
                    // Master ACK defers the next byte's first bit to the fall closing this slot
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_state    <= S_RD_BYTE;
                                r_tx_first <= 1'b1;
                            end else begin
                                r_state <= S_WAIT_STOP;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    // Commit lags wr_valid by one cycle; reads are registered and settle long before use
    always_ff @(posedge sys_clk) begin
        if (r_wr_valid) r_mem[r_wr_addr] <= r_wr_data;
        r_mem_q <= r_mem[r_ptr];
    end

    assign i2c_sda  = r_sda_oe ? 1'b0 : 1'bz;
    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_mem.sv
`timescale 1ns/1ps
// Bench for i2c_slave_mem: bit-banged I2C master against a 2-byte-address target and a
// 1-byte-address target on separate SDA lines, checked against a transaction-level memory model.
module tb_i2c_slave_mem;

    localparam int Q = 6;

    typedef struct packed { logic [9:0] a; logic [7:0] d; } wev_t;
    typedef struct { logic [15:0] a; logic [7:0] d; logic [9:0] exp_a; } vec_t;

    logic clk = 1'b0;
    logic rst, m_scl, m_sda, sel;
    wire  sda0, sda1;
    logic busy0, wv0, busy1, wv1;
    logic [9:0] wa0, wa1;
    logic [7:0] wd0, wd1;

    pullup pu0 (sda0);
    pullup pu1 (sda1);
    assign sda0 = (!sel && !m_sda) ? 1'b0 : 1'bz;
    assign sda1 = ( sel && !m_sda) ? 1'b0 : 1'bz;

    i2c_slave_mem #(.DEVICE_ADDR(7'h53), .ADDR_NUM(1'b1), .MEM_AW(10)) u_dut0 (
        .sys_clk(clk), .sys_rst(rst), .i2c_scl(m_scl), .i2c_sda(sda0),
        .busy(busy0), .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0));

    i2c_slave_mem #(.DEVICE_ADDR(7'h53), .ADDR_NUM(1'b0), .MEM_AW(10)) u_dut1 (
        .sys_clk(clk), .sys_rst(rst), .i2c_scl(m_scl), .i2c_sda(sda1),
        .busy(busy1), .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1));

    always #10 clk = ~clk;

    int n_err = 0, n_chk = 0, g_acks;
    wev_t wq[$], exp_q[$];
    logic [7:0] wbuf[16], rbuf[16];
    logic [7:0] m_mem[1024];
    bit m_known[1024];
    int m_ptr;
    vec_t tbl[6];

    always @(negedge clk) begin
        if (wv0) wq.push_back({wa0, wd0});
        if (wv1) wq.push_back({wa1, wd1});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;  qwait();
        m_scl = 1'b1; qwait();
        r = sel ? sda1 : sda0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
    endtask

    task automatic wbyte(input logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        if (!r) g_acks++;
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d = {d[6:0], r};
        end
        bit_xfer(nack, r);
    endtask

    task automatic xfer_write(input logic [15:0] a, input int n);
        g_acks = 0;
        i2c_start();
        wbyte(8'hA6);
        if (!sel) wbyte(a[15:8]);
        wbyte(a[7:0]);
        for (int i = 0; i < n; i++) wbyte(wbuf[i]);
        i2c_stop();
    endtask

    task automatic xfer_read(input logic do_addr, input logic [15:0] a, input int n);
        g_acks = 0;
        i2c_start();
        if (do_addr) begin
            wbyte(8'hA6); wbyte(a[15:8]); wbyte(a[7:0]);
            i2c_start();
        end
        wbyte(8'hA7);
        for (int i = 0; i < n; i++) rbyte(i == n - 1, rbuf[i]);
        i2c_stop();
    endtask

    // Memory model: the low 10 bits of the word address select a byte; the pointer wraps at 1024
    task automatic model_write(input logic [15:0] a, input int n);
        m_ptr = int'(a) % 1024;
        for (int i = 0; i < n; i++) begin
            m_mem[m_ptr]   = wbuf[i];
            m_known[m_ptr] = 1'b1;
            exp_q.push_back({10'(m_ptr), wbuf[i]});
            m_ptr = (m_ptr + 1) % 1024;
        end
    endtask

    task automatic model_read_check(input int start, input int n);
        int p;
        p = start;
        for (int i = 0; i < n; i++) begin
            if (m_known[p]) chk("rd_data", int'(rbuf[i]), int'(m_mem[p]));
            p = (p + 1) % 1024;
        end
        m_ptr = p;
    endtask

    task automatic check_wr();
        wev_t e, g;
        chk("wr_count", wq.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (wq.size() > 0) begin
                g = wq.pop_front();
                chk("wr_addr", int'(g.a), int'(e.a));
                chk("wr_data", int'(g.d), int'(e.d));
            end
        end
        wq.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic r;
        logic [15:0] a, last_a;
        int n, last_n, kind;

        tbl[0] = '{16'h0000, 8'h5A, 10'h000};
        tbl[1] = '{16'h03FE, 8'hC3, 10'h3FE};
        tbl[2] = '{16'hFC01, 8'h01, 10'h001};
        tbl[3] = '{16'h1234, 8'hFF, 10'h234};
        tbl[4] = '{16'h8155, 8'h00, 10'h155};
        tbl[5] = '{16'h0200, 8'h96, 10'h200};

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; sel = 1'b0; m_ptr = 0;
        repeat (5) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_wr_valid", wv0, 0);
        chk("rst_wr_addr", int'(wa0), 0);
        chk("rst_wr_data", int'(wd0), 0);
        chk("rst_sda_released", sda0, 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single-byte write at 0x0012
        wbuf[0] = 8'hA5;
        xfer_write(16'h0012, 1);
        chk("wr_acks", g_acks, 4);
        model_write(16'h0012, 1);
        check_wr();
        chk("wr_busy_after_stop", busy0, 0);

        // Random read via dummy write and repeated START
        g_acks = 0;
        i2c_start();
        wbyte(8'hA6); wbyte(8'h00); wbyte(8'h12);
        chk("rr_busy_mid", busy0, 1);
        i2c_start();
        wbyte(8'hA7);
        rbyte(1'b1, d);
        i2c_stop();
        chk("rr_acks", g_acks, 4);
        chk("rr_data", int'(d), 8'hA5);
        chk("rr_busy_after_stop", busy0, 0);
        m_ptr = 16'h13;

        // Wrong device address: no ACK, no busy, no commit; bus recovers
        g_acks = 0;
        i2c_start();
        wbyte(8'hB0);
        chk("wa_busy", busy0, 0);
        wbyte(8'h55);
        i2c_stop();
        chk("wa_acks", g_acks, 0);
        check_wr();
        xfer_read(1'b1, 16'h0012, 1);
        chk("wa_next_acks", g_acks, 4);
        model_read_check(16'h012, 1);

        // Burst write across the top of memory, then read it back
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write(16'h03FF, 2);
        chk("wrap_wr_acks", g_acks, 5);
        model_write(16'h03FF, 2);
        check_wr();
        xfer_read(1'b1, 16'h03FF, 2);
        chk("wrap_rd_data0", int'(rbuf[0]), 8'h11);
        chk("wrap_rd_data1", int'(rbuf[1]), 8'h22);
        m_ptr = 1;

        // Reset while the target drives a 0 bit of 0xA5
        g_acks = 0;
        i2c_start();
        wbyte(8'hA6); wbyte(8'h00); wbyte(8'h12);
        i2c_start();
        wbyte(8'hA7);
        chk("rm_acks", g_acks, 4);
        bit_xfer(1'b1, r);
        chk("rm_bit7", r, 1);
        chk("rm_sda_driven0", sda0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_sda_released", sda0, 1);
        chk("rm_busy", busy0, 0);
        rst = 1'b0;
        m_ptr = 0;
        repeat (3) @(negedge clk);
        i2c_stop();
        xfer_read(1'b0, 16'h0000, 1);
        chk("rm_next_acks", g_acks, 1);
        model_read_check(m_ptr, 1);

        // One-byte word address build
        sel = 1'b1;
        wbuf[0] = 8'h3C;
        xfer_write(16'h0005, 1);
        chk("a1_acks", g_acks, 3);
        exp_q.push_back({10'h005, 8'h3C});
        check_wr();
        sel = 1'b0;

        // Table of single-byte writes exercising address truncation, each read back
        for (int i = 0; i < 6; i++) begin
            wbuf[0] = tbl[i].d;
            xfer_write(tbl[i].a, 1);
            chk("tbl_wr_acks", g_acks, 4);
            chk("tbl_wr_count", wq.size(), 1);
            if (wq.size() > 0) begin
                chk("tbl_wr_addr", int'(wq[0].a), int'(tbl[i].exp_a));
                chk("tbl_wr_data", int'(wq[0].d), int'(tbl[i].d));
            end
            wq.delete();
            m_mem[tbl[i].exp_a] = tbl[i].d;
            m_known[tbl[i].exp_a] = 1'b1;
            xfer_read(1'b1, tbl[i].a, 1);
            chk("tbl_rd_data", int'(rbuf[0]), int'(tbl[i].d));
            m_ptr = (int'(tbl[i].exp_a) + 1) % 1024;
        end

        // Randomized transactions against the model
        last_a = 16'h03FF; last_n = 2;
        for (int t = 0; t < 10; t++) begin
            kind = (t == 0) ? 0 : int'($urandom_range(0, 2));
            if (kind == 0) begin
                n = int'($urandom_range(1, 4));
                a = 16'($urandom);
                if ($urandom_range(0, 2) == 0) a = {6'($urandom), 10'h3FE};
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                xfer_write(a, n);
                chk("rnd_wr_acks", g_acks, n + 3);
                model_write(a, n);
                check_wr();
                last_a = a; last_n = n;
            end else if (kind == 1) begin
                n = int'($urandom_range(1, last_n));
                xfer_read(1'b1, last_a, n);
                chk("rnd_rd_acks", g_acks, 4);
                model_read_check(int'(last_a) % 1024, n);
            end else begin
                n = int'($urandom_range(1, 3));
                xfer_read(1'b0, 16'h0000, n);
                chk("rnd_cur_acks", g_acks, 1);
                model_read_check(m_ptr, n);
            end
            chk("rnd_busy_idle", busy0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
